// File: rtl/forthsuper_pkg.sv
// Shared types and constants for the forthsuper data-stack path.
// Both the controller and the memory stack peer import this package.
package forthsuper_pkg;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;

  typedef enum logic [1:0] {
    SS_NOP  = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2
  } stack_ops;

  typedef enum logic [2:0] {
    DS_NOP  = 3'd0,
    DS_PUSH = 3'd1,
    DS_DROP = 3'd2,
    DS_DUP  = 3'd3,
    DS_SWAP = 3'd4,
    DS_OVER = 3'd5,
    DS_NIP  = 3'd6
  } ds_cmd;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } ds_state;

  // Minimum element count a command needs before it may execute.
  function automatic logic [1:0] ds_need(input ds_cmd op);
    case (op)
      DS_DUP, DS_DROP:          return 2'd1;
      DS_SWAP, DS_OVER, DS_NIP: return 2'd2;
      default:                  return 2'd0;
    endcase
  endfunction

  function automatic logic ds_grows(input ds_cmd op);
    return (op == DS_PUSH) || (op == DS_DUP) || (op == DS_OVER);
  endfunction

endpackage

// File: rtl/dstack_ctl.sv
// Data-stack controller: keeps T and N in registers and spills/fills the
// rest of the stack through an external memory stack peer.
module dstack_ctl
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = forthsuper_pkg::DEPTH,
  parameter int DSZ   = forthsuper_pkg::DSZ,
  parameter int CSZ   = $clog2(DEPTH + 3)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  ds_cmd          cmd_op,
  input  logic [DSZ-1:0] cmd_v,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [CSZ-1:0] depth,
  output logic           err,
  output logic           ovf,
  output logic           unf,
  output stack_ops       ss_op,
  output logic [DSZ-1:0] ss_vi,
  input  logic [DSZ-1:0] ss_s,
  output logic           ss_en
);

  localparam logic [CSZ-1:0] ONE   = CSZ'(1);
  localparam logic [CSZ-1:0] TWO   = CSZ'(2);
  localparam logic [CSZ-1:0] MAX_D = CSZ'(DEPTH + 2);

  ds_state        state_reg, state_next;
  logic [DSZ-1:0] t_reg, t_next;
  logic [DSZ-1:0] n_reg, n_next;
  logic [CSZ-1:0] depth_reg, depth_next;
  logic           err_reg, err_next;
  logic           ovf_reg, ovf_next;
  logic           unf_reg, unf_next;

  logic accept;
  logic under;
  logic full;

  assign cmd_ready = (state_reg == ST_IDLE);
  // Gating with rst keeps the memory stack idle while reset is held.
  assign accept    = cmd_valid && cmd_ready && rst;
  assign under     = depth_reg < CSZ'(ds_need(cmd_op));
  assign full      = ds_grows(cmd_op) && (depth_reg == MAX_D);

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    n_next     = n_reg;
    depth_next = depth_reg;
    err_next   = 1'b0;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    ss_op      = SS_NOP;
    ss_vi      = '0;

    case (state_reg)
      ST_FILL: begin
        n_next     = ss_s;
        state_next = ST_IDLE;
      end
      default: begin
        if (accept) begin
          if (under) begin
            err_next = 1'b1;
            unf_next = 1'b1;
          end else if (full) begin
            err_next = 1'b1;
            ovf_next = 1'b1;
          end else begin
            // Growing commands push the old N out once T and N are both live.
            if (ds_grows(cmd_op) && (depth_reg >= TWO)) begin
              ss_op = SS_PUSH;
              ss_vi = n_reg;
            end
            case (cmd_op)
              DS_PUSH: begin
                t_next     = cmd_v;
                n_next     = t_reg;
                depth_next = depth_reg + ONE;
              end
              DS_DUP: begin
                n_next     = t_reg;
                depth_next = depth_reg + ONE;
              end
              DS_OVER: begin
                t_next     = n_reg;
                n_next     = t_reg;
                depth_next = depth_reg + ONE;
              end
              DS_SWAP: begin
                t_next = n_reg;
                n_next = t_reg;
              end
              DS_DROP, DS_NIP: begin
                if (cmd_op == DS_DROP) t_next = n_reg;
                depth_next = depth_reg - ONE;
                if (depth_reg > TWO) begin
                  ss_op      = SS_POP;
                  state_next = ST_FILL;
                end else begin
                  n_next = '0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (!rst) begin
      ss_op = SS_NOP;
      ss_vi = '0;
    end
  end

  assign ss_en = (ss_op != SS_NOP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      t_reg     <= '0;
      n_reg     <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      n_reg     <= n_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign tos   = t_reg;
  assign nos   = n_reg;
  assign depth = depth_reg;
  assign err   = err_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;

endmodule

// File: tb/tb_dstack_ctl.sv
// Directed bench for dstack_ctl with a small behavioural memory stack peer.
module tb_dstack_ctl;
  import forthsuper_pkg::*;

  localparam int TD  = 4;
  localparam int TW  = 32;
  localparam int TC  = $clog2(TD + 3);
  localparam int NV  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  ds_cmd         cmd_op = DS_NOP;
  logic [TW-1:0] cmd_v = '0;
  logic [TW-1:0] tos, nos, ss_vi, ss_s;
  logic [TC-1:0] depth;
  logic          err, ovf, unf, ss_en;
  stack_ops      ss_op;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dstack_ctl #(.DEPTH(TD), .DSZ(TW), .CSZ(TC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_v(cmd_v), .tos(tos), .nos(nos), .depth(depth),
    .err(err), .ovf(ovf), .unf(unf), .ss_op(ss_op), .ss_vi(ss_vi),
    .ss_s(ss_s), .ss_en(ss_en)
  );

  // Memory stack peer: PUSH stores now, POP presents data next cycle.
  logic [TW-1:0] mem [0:7];
  int            sp;
  logic [TW-1:0] rd_q = '0;
  assign ss_s = rd_q;

  always @(posedge clk) begin
    if (!rst) begin
      sp <= 0;
    end else if (ss_en) begin
      if (ss_op == SS_PUSH && sp < 8) begin
        mem[sp] <= ss_vi;
        sp      <= sp + 1;
      end else if (ss_op == SS_POP && sp > 0) begin
        rd_q <= mem[sp-1];
        sp   <= sp - 1;
      end
    end
  end

  typedef struct {
    ds_cmd         op;
    logic [TW-1:0] v;
    logic [TW-1:0] e_tos;
    logic [TW-1:0] e_nos;
    int            e_depth;
    bit            e_err;
    bit            e_ovf;
    bit            e_unf;
    stack_ops      e_ss;
    logic [TW-1:0] e_vi;
    bit            e_fill;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic run_vec(input int idx, input vec_t vc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = vc.op;
    cmd_v     = vc.v;
    #1;
    chk("ss_op", 32'(ss_op), 32'(vc.e_ss));
    chk("ss_en", 32'(ss_en), 32'(vc.e_ss != SS_NOP));
    if (vc.e_ss == SS_PUSH) chk("ss_vi", ss_vi, vc.e_vi);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("tos", tos, vc.e_tos);
    chk("depth", 32'(depth), 32'(vc.e_depth));
    chk("err", 32'(err), 32'(vc.e_err));
    chk("ovf", 32'(ovf), 32'(vc.e_ovf));
    chk("unf", 32'(unf), 32'(vc.e_unf));
    if (vc.e_fill) begin
      chk("ready_fill", 32'(cmd_ready), 32'd0);
      chk("ss_op_fill", 32'(ss_op), 32'(SS_NOP));
    end else begin
      chk("nos", nos, vc.e_nos);
    end
    @(posedge clk);
    #1;
    chk("err_pulse", 32'(err), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
    if (vc.e_fill) chk("nos_fill", nos, vc.e_nos);
    $display("vec %0d op=%s v=%0d -> tos=%0d nos=%0d depth=%0d err=%0b ovf=%0b unf=%0b",
             idx, vc.op.name(), vc.v, tos, nos, depth, vc.e_err, ovf, unf);
  endtask

  initial begin
    // op, v, tos, nos, depth, err, ovf, unf, ss_op, ss_vi, fill
    vecs[0]  = '{DS_PUSH, 1,  1,  0, 1, 0, 0, 0, SS_NOP,  0, 0};
    vecs[1]  = '{DS_PUSH, 2,  2,  1, 2, 0, 0, 0, SS_NOP,  0, 0};
    vecs[2]  = '{DS_PUSH, 3,  3,  2, 3, 0, 0, 0, SS_PUSH, 1, 0};
    vecs[3]  = '{DS_DROP, 0,  2,  1, 2, 0, 0, 0, SS_POP,  0, 1};
    vecs[4]  = '{DS_DROP, 0,  1,  0, 1, 0, 0, 0, SS_NOP,  0, 0};
    vecs[5]  = '{DS_DROP, 0,  0,  0, 0, 0, 0, 0, SS_NOP,  0, 0};
    vecs[6]  = '{DS_DROP, 0,  0,  0, 0, 1, 0, 1, SS_NOP,  0, 0};
    vecs[7]  = '{DS_PUSH, 9,  9,  0, 1, 0, 0, 1, SS_NOP,  0, 0};
    vecs[8]  = '{DS_PUSH, 5,  5,  9, 2, 0, 0, 1, SS_NOP,  0, 0};
    vecs[9]  = '{DS_PUSH, 7,  7,  5, 3, 0, 0, 1, SS_PUSH, 9, 0};
    vecs[10] = '{DS_SWAP, 0,  5,  7, 3, 0, 0, 1, SS_NOP,  0, 0};
    vecs[11] = '{DS_OVER, 0,  7,  5, 4, 0, 0, 1, SS_PUSH, 7, 0};
    vecs[12] = '{DS_NIP,  0,  7,  7, 3, 0, 0, 1, SS_POP,  0, 1};
    vecs[13] = '{DS_DUP,  0,  7,  7, 4, 0, 0, 1, SS_PUSH, 7, 0};
    vecs[14] = '{DS_PUSH, 10, 10, 7, 5, 0, 0, 1, SS_PUSH, 7, 0};
    vecs[15] = '{DS_PUSH, 11, 11, 10, 6, 0, 0, 1, SS_PUSH, 7, 0};
    vecs[16] = '{DS_PUSH, 12, 11, 10, 6, 1, 1, 1, SS_NOP,  0, 0};
    vecs[17] = '{DS_DUP,  0,  11, 10, 6, 1, 1, 1, SS_NOP,  0, 0};
    vecs[18] = '{DS_SWAP, 0,  10, 11, 6, 0, 1, 1, SS_NOP,  0, 0};
    vecs[19] = '{DS_NIP,  0,  10, 7, 5, 0, 1, 1, SS_POP,  0, 1};

    // Reset held with a command offered: memory stack must stay idle.
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = DS_PUSH;
    cmd_v     = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_op", 32'(ss_op), 32'(SS_NOP));
    chk("rst_ss_en", 32'(ss_en), 32'd0);
    chk("rst_tos", tos, 32'd0);
    chk("rst_nos", nos, 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_flags", {29'd0, err, ovf, unf}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // NOP accepted with no effect; sticky flags unchanged.
    run_vec(NV, '{DS_NOP, 0, 10, 7, 5, 0, 1, 1, SS_NOP, 0, 0});

    // Reset asserted during the FILL cycle abandons the fill.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = DS_DROP;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("fill_busy", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("fill_rst_ss_op", 32'(ss_op), 32'(SS_NOP));
    @(posedge clk);
    #1;
    chk("fill_rst_tos", tos, 32'd0);
    chk("fill_rst_nos", nos, 32'd0);
    chk("fill_rst_depth", 32'(depth), 32'd0);
    chk("fill_rst_ready", 32'(cmd_ready), 32'd1);
    chk("fill_rst_ss_op2", 32'(ss_op), 32'(SS_NOP));
    chk("fill_rst_sticky", {30'd0, ovf, unf}, 32'd0);
    $display("reset in FILL -> tos=%0d nos=%0d depth=%0d ready=%0b", tos, nos, depth, cmd_ready);
    @(negedge clk);
    rst = 1'b1;

    // Two-element commands with only one element present underflow.
    run_vec(NV + 1, '{DS_PUSH, 4, 4, 0, 1, 0, 0, 0, SS_NOP, 0, 0});
    run_vec(NV + 2, '{DS_NIP,  0, 4, 0, 1, 1, 0, 1, SS_NOP, 0, 0});
    run_vec(NV + 3, '{DS_SWAP, 0, 4, 0, 1, 1, 0, 1, SS_NOP, 0, 0});
    run_vec(NV + 4, '{DS_OVER, 0, 4, 0, 1, 1, 0, 1, SS_NOP, 0, 0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
